// File: rtl/i3_router_rr_arbiter.sv
// ---------------------------------------------------------------------------
// i3_router_rr_arbiter
// Packet-granular round-robin arbiter for one router output FIFO shared by
// three input ports. A head flit wins the write path and holds it until its
// tail flit is written (wormhole lock). Also flags protocol violations and
// releases stalled packets through an idle watchdog.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   input_req1/2/3             port N presents a valid flit this cycle
//   head1/2/3   [2:0]          flit-type field of port N's presented flit
//   FIFO_full                  output FIFO cannot accept a write this cycle
//   FIFO_wr                    write selected port's flit (combinational)
//   select      [1:0]          flit mux select: 0 port1, 1 port2, 2 port3
//   input_bussy1/2/3           0 = port N's flit consumed, 1 = hold (comb.)
//   owner_vld                  registered, high while a packet lock is held
//   pkt_done                   registered pulse, cycle after a tail write
//   proto_err                  registered pulse on a protocol violation
//   timeout_err                registered pulse on a watchdog release
// ---------------------------------------------------------------------------
module i3_router_rr_arbiter #(
    parameter logic [2:0] HEAD    = 3'b001,
    parameter logic [2:0] TAIL    = 3'b110,
    parameter logic [7:0] TIMEOUT = 8'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       input_req1,
    input  logic       input_req2,
    input  logic       input_req3,
    input  logic [2:0] head1,
    input  logic [2:0] head2,
    input  logic [2:0] head3,
    input  logic       FIFO_full,
    output logic       FIFO_wr,
    output logic [1:0] select,
    output logic       input_bussy1,
    output logic       input_bussy2,
    output logic       input_bussy3,
    output logic       owner_vld,
    output logic       pkt_done,
    output logic       proto_err,
    output logic       timeout_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Registered state
    state_t             r_state;
    logic [1:0]         r_owner;
    logic [1:0]         r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_owner_vld;
    logic               r_pkt_done;
    logic               r_proto_err;
    logic               r_timeout_err;

    // Next-state and combinational decode
    state_t             w_state_nxt;
    logic [1:0]         w_owner_nxt;
    logic [1:0]         w_last_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_done_nxt;
    logic               w_perr_nxt;
    logic               w_tmo_nxt;
    logic               w_wr;
    logic [1:0]         w_sel;
    logic [2:0]         w_bussy;

    // Port 3 slot is a permanently idle pad so a 2-bit index never runs off the end
    logic [3:0]         w_req;
    logic [2:0]         w_typ [4];
    logic [3:0]         w_elig;
    logic [3:0]         w_stray;
    logic [1:0]         w_p0;
    logic [1:0]         w_p1;
    logic [1:0]         w_p2;
    logic               w_found;
    logic [1:0]         w_win;

    assign w_req    = {1'b0, input_req3, input_req2, input_req1};
    assign w_typ[0] = head1;
    assign w_typ[1] = head2;
    assign w_typ[2] = head3;
    assign w_typ[3] = 3'b000;

    // Round-robin successor over ports 0..2
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : 2'(p + 2'd1);
    endfunction

    // Per-port eligibility for a new grant, and stray (non-head) flits seen in IDLE
    always_comb begin
        w_elig  = '0;
        w_stray = '0;
        for (int i = 0; i < 4; i++) begin
            w_elig[i]  = w_req[i] && (w_typ[i] == HEAD) && !FIFO_full;
            w_stray[i] = w_req[i] && (w_typ[i] != HEAD);
        end
    end

    // Winner search starting one past the most recent winner
    always_comb begin
        w_p0    = next_port(r_last);
        w_p1    = next_port(w_p0);
        w_p2    = next_port(w_p1);
        w_found = 1'b1;
        w_win   = w_p0;
        if (w_elig[w_p0]) begin
            w_win = w_p0;
        end else if (w_elig[w_p1]) begin
            w_win = w_p1;
        end else if (w_elig[w_p2]) begin
            w_win = w_p2;
        end else begin
            w_found = 1'b0;
        end
    end

    // Next-state and write-path decode
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;
        w_tmo_nxt   = 1'b0;
        w_wr        = 1'b0;
        w_sel       = 2'b00;
        w_bussy     = 3'b111;

        case (r_state)
            ST_IDLE: begin
                // Stray flits are drained (not written) on every port concurrently
                for (int i = 0; i < 3; i++) begin
                    if (w_stray[i]) begin
                        w_bussy[i] = 1'b0;
                    end
                end
                w_perr_nxt = |w_stray;
                if (w_found) begin
                    w_wr           = 1'b1;
                    w_sel          = w_win;
                    w_bussy[w_win] = 1'b0;
                    w_state_nxt    = ST_LOCK;
                    w_owner_nxt    = w_win;
                    w_last_nxt     = w_win;
                    w_cnt_nxt      = '0;
                end
            end

            ST_LOCK: begin
                w_sel = r_owner;
                if (w_req[r_owner]) begin
                    if (w_typ[r_owner] == HEAD) begin
                        // Duplicate head inside a packet: drop it, keep the lock
                        w_bussy[r_owner] = 1'b0;
                        w_perr_nxt       = 1'b1;
                    end else if (!FIFO_full) begin
                        w_wr             = 1'b1;
                        w_bussy[r_owner] = 1'b0;
                        w_cnt_nxt        = '0;
                        if (w_typ[r_owner] == TAIL) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end else if (!FIFO_full) begin
                    // Owner idle while the FIFO could accept: watchdog runs
                    if (r_cnt == TIMEOUT - 8'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_tmo_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= 2'b00;
            r_last        <= 2'b10;
            r_cnt         <= '0;
            r_owner_vld   <= 1'b0;
            r_pkt_done    <= 1'b0;
            r_proto_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last        <= w_last_nxt;
            r_cnt         <= w_cnt_nxt;
            r_owner_vld   <= (w_state_nxt == ST_LOCK);
            r_pkt_done    <= w_done_nxt;
            r_proto_err   <= w_perr_nxt;
            r_timeout_err <= w_tmo_nxt;
        end
    end

    // Combinational outputs are forced safe while reset is asserted
    assign FIFO_wr      = rst_n & w_wr;
    assign select       = rst_n ? w_sel : 2'b00;
    assign input_bussy1 = ~rst_n | w_bussy[0];
    assign input_bussy2 = ~rst_n | w_bussy[1];
    assign input_bussy3 = ~rst_n | w_bussy[2];

    assign owner_vld   = r_owner_vld;
    assign pkt_done    = r_pkt_done;
    assign proto_err   = r_proto_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_i3_router_rr_arbiter.sv
module tb_i3_router_rr_arbiter;

    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] B = 3'b010;
    localparam logic [2:0] T = 3'b110;
    localparam logic [2:0] Z = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       input_req1, input_req2, input_req3;
    logic [2:0] head1, head2, head3;
    logic       FIFO_full;
    logic       FIFO_wr;
    logic [1:0] select;
    logic       input_bussy1, input_bussy2, input_bussy3;
    logic       owner_vld, pkt_done, proto_err, timeout_err;

    always #5 clk = ~clk;

    i3_router_rr_arbiter #(
        .HEAD    (3'b001),
        .TAIL    (3'b110),
        .TIMEOUT (8'd4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_req1   (input_req1),
        .input_req2   (input_req2),
        .input_req3   (input_req3),
        .head1        (head1),
        .head2        (head2),
        .head3        (head3),
        .FIFO_full    (FIFO_full),
        .FIFO_wr      (FIFO_wr),
        .select       (select),
        .input_bussy1 (input_bussy1),
        .input_bussy2 (input_bussy2),
        .input_bussy3 (input_bussy3),
        .owner_vld    (owner_vld),
        .pkt_done     (pkt_done),
        .proto_err    (proto_err),
        .timeout_err  (timeout_err)
    );

    // req and busy are {port3, port2, port1}
    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] t1, t2, t3;
        logic       full;
        logic       wr;
        logic [1:0] sel;
        logic [2:0] busy;
        logic       vld, done, perr, tmo;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic rst, input logic [2:0] req,
                                input logic [2:0] t1, input logic [2:0] t2, input logic [2:0] t3,
                                input logic full, input logic wr, input logic [1:0] sel,
                                input logic [2:0] busy, input logic vld, input logic done,
                                input logic perr, input logic tmo);
        vec_t v;
        v.rst = rst; v.req = req; v.t1 = t1; v.t2 = t2; v.t3 = t3; v.full = full;
        v.wr = wr; v.sel = sel; v.busy = busy; v.vld = vld; v.done = done;
        v.perr = perr; v.tmo = tmo;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [2:0] req, input logic [2:0] t1,
                         input logic [2:0] t2, input logic [2:0] t3, input logic full);
        rst_n      = rst;
        input_req1 = req[0];
        input_req2 = req[1];
        input_req3 = req[2];
        head1      = t1;
        head2      = t2;
        head3      = t3;
        FIFO_full  = full;
    endtask

    task automatic check_all(input int row, input logic wr, input logic [1:0] sel,
                             input logic [2:0] busy, input logic vld, input logic done,
                             input logic perr, input logic tmo);
        chk("FIFO_wr",     row, {2'b00, FIFO_wr},   {2'b00, wr});
        chk("select",      row, {1'b0, select},     {1'b0, sel});
        chk("bussy",       row, {input_bussy3, input_bussy2, input_bussy1}, busy);
        chk("owner_vld",   row, {2'b00, owner_vld}, {2'b00, vld});
        chk("pkt_done",    row, {2'b00, pkt_done},  {2'b00, done});
        chk("proto_err",   row, {2'b00, proto_err}, {2'b00, perr});
        chk("timeout_err", row, {2'b00, timeout_err}, {2'b00, tmo});
    endtask

    initial begin
        drive(1'b0, 3'b000, Z, Z, Z, 1'b0);

        //             rst  req     t1 t2 t3 full wr sel  busy   vld done perr tmo
        // reset state
        vecs.push_back(mk(0, 3'b111, H, H, H, 0,  0, 2'd0, 3'b111, 0, 0, 0, 0));
        // single port1 packet H,B,B,T
        vecs.push_back(mk(1, 3'b001, H, Z, Z, 0,  1, 2'd0, 3'b110, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, B, Z, Z, 0,  1, 2'd0, 3'b110, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, B, Z, Z, 0,  1, 2'd0, 3'b110, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, T, Z, Z, 0,  1, 2'd0, 3'b110, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 0,  0, 2'd0, 3'b111, 0, 1, 0, 0));
        // reset to restore port1 priority, then fairness with 2-flit packets
        vecs.push_back(mk(0, 3'b000, Z, Z, Z, 0,  0, 2'd0, 3'b111, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b111, H, H, H, 0,  1, 2'd0, 3'b110, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b111, T, H, H, 0,  1, 2'd0, 3'b110, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b111, H, H, H, 0,  1, 2'd1, 3'b101, 0, 1, 0, 0));
        vecs.push_back(mk(1, 3'b111, H, T, H, 0,  1, 2'd1, 3'b101, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b111, H, H, H, 0,  1, 2'd2, 3'b011, 0, 1, 0, 0));
        vecs.push_back(mk(1, 3'b111, H, H, T, 0,  1, 2'd2, 3'b011, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b111, H, H, H, 0,  1, 2'd0, 3'b110, 0, 1, 0, 0));
        vecs.push_back(mk(1, 3'b001, T, Z, Z, 0,  1, 2'd0, 3'b110, 1, 0, 0, 0));
        // backpressure on port2; idle counter must hold while full
        vecs.push_back(mk(1, 3'b010, Z, H, Z, 0,  1, 2'd1, 3'b101, 0, 1, 0, 0));
        vecs.push_back(mk(1, 3'b010, Z, B, Z, 0,  1, 2'd1, 3'b101, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 0,  0, 2'd1, 3'b111, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 1,  0, 2'd1, 3'b111, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 1,  0, 2'd1, 3'b111, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 1,  0, 2'd1, 3'b111, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, Z, B, Z, 1,  0, 2'd1, 3'b111, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 0,  0, 2'd1, 3'b111, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, Z, T, Z, 0,  1, 2'd1, 3'b101, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 0,  0, 2'd0, 3'b111, 0, 1, 0, 0));
        // watchdog: port3 head then silence for TIMEOUT=4 cycles
        vecs.push_back(mk(1, 3'b100, Z, Z, H, 0,  1, 2'd2, 3'b011, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 0,  0, 2'd2, 3'b111, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 0,  0, 2'd2, 3'b111, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 0,  0, 2'd2, 3'b111, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 0,  0, 2'd2, 3'b111, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, H, Z, Z, 0,  1, 2'd0, 3'b110, 0, 0, 0, 1));
        // duplicate head from owner port1; port2 body waits without error
        vecs.push_back(mk(1, 3'b011, H, B, Z, 0,  0, 2'd0, 3'b110, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b011, T, B, Z, 0,  1, 2'd0, 3'b110, 1, 0, 1, 0));
        // port2 body now stray in IDLE
        vecs.push_back(mk(1, 3'b010, Z, B, Z, 0,  0, 2'd0, 3'b101, 0, 1, 0, 0));
        vecs.push_back(mk(1, 3'b000, Z, Z, Z, 0,  0, 2'd0, 3'b111, 0, 0, 1, 0));
        // head blocked by a full FIFO in IDLE
        vecs.push_back(mk(1, 3'b001, H, Z, Z, 1,  0, 2'd0, 3'b111, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].req, vecs[i].t1, vecs[i].t2, vecs[i].t3, vecs[i].full);
            #1;
            check_all(i, vecs[i].wr, vecs[i].sel, vecs[i].busy,
                      vecs[i].vld, vecs[i].done, vecs[i].perr, vecs[i].tmo);
        end

        // Async reset mid-packet (last winner is port1, so port2 would be next without reset)
        @(negedge clk);
        drive(1'b1, 3'b001, H, Z, Z, 1'b0);
        #1;
        check_all(100, 1'b1, 2'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b001, B, Z, Z, 1'b0);
        #1;
        check_all(101, 1'b1, 2'd0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        drive(1'b0, 3'b001, B, Z, Z, 1'b0);
        #1;
        check_all(102, 1'b0, 2'd0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b111, H, H, H, 1'b0);
        #1;
        check_all(103, 1'b1, 2'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b000, Z, Z, Z, 1'b0);
        #1;
        check_all(104, 1'b0, 2'd0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
